// File: rtl/control_pkg.sv
// Shared control-decode types: opcode encodings, ALU op classes and the
// packed control bundle driven toward the ID/EX stage.
package control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_VEC    = 7'b0100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       is_vector;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_VEC} state_e;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode -> control bundle decoder; unknown opcodes decode to
// an all-zero NOP bundle with illegal raised.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_FUNCT; end
      OP_ITYPE:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_FUNCT; end
      OP_LOAD:   begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_STORE:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_BR; end
      OP_LUI:    begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_PASS; end
      OP_VEC:    begin ctrl.reg_write = 1'b1; ctrl.is_vector = 1'b1; ctrl.alu_op = ALU_PASS; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_control_seq.sv
// Registered control decoder with valid/ready output; vector opcodes are
// expanded into ceil(VLEN/LANES) beats while upstream is held off.
module vector_control_seq
  import control_pkg::*;
#(
  parameter int VLEN  = 8,
  parameter int LANES = 2,
  parameter int IDX_W = $clog2(VLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch,
  output logic             is_vector,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [IDX_W-1:0] vec_idx,
  output logic [LANES-1:0] lane_en,
  output logic             vec_last
);

  localparam int NBEATS = (VLEN + LANES - 1) / LANES;

  generate
    if (LANES > VLEN || LANES < 1) begin : g_param_chk
      $error("vector_control_seq: LANES must satisfy 1 <= LANES <= VLEN");
    end
  endgenerate

  function automatic logic [LANES-1:0] lane_mask(input logic [IDX_W:0] idx);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (32'(idx) + i < VLEN);
    return m;
  endfunction

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  control_decode u_dec (.opcode(opcode), .ctrl(dec_ctrl), .illegal(dec_illegal));

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [LANES-1:0] lane_en_q, lane_en_d;
  logic             vec_last_q, vec_last_d;
  logic [IDX_W:0]   nidx;
  logic             accept;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // One extra bit so the step past the final beat can never wrap.
  assign nidx     = {1'b0, vec_idx_q} + (IDX_W+1)'(LANES);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    vec_idx_d   = vec_idx_q;
    lane_en_d   = lane_en_q;
    vec_last_d  = vec_last_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          ctrl_d      = dec_ctrl;
          illegal_d   = dec_illegal;
          vec_idx_d   = '0;
          if (dec_ctrl.is_vector) begin
            lane_en_d  = lane_mask('0);
            vec_last_d = (NBEATS == 1);
            if (NBEATS > 1) state_d = S_VEC;
          end else begin
            lane_en_d  = '1;
            vec_last_d = 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_VEC: begin
        if (out_ready) begin
          if (vec_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end else begin
            vec_idx_d  = nidx[IDX_W-1:0];
            lane_en_d  = lane_mask(nidx);
            vec_last_d = (32'(nidx) + LANES >= VLEN);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      vec_idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      vec_idx_q   <= '0;
      lane_en_q   <= '0;
      vec_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      vec_idx_q   <= vec_idx_d;
      lane_en_q   <= lane_en_d;
      vec_last_q  <= vec_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign alu_op     = ctrl_q.alu_op;
  assign branch     = ctrl_q.branch;
  assign is_vector  = ctrl_q.is_vector;
  assign illegal    = illegal_q;
  assign vec_idx    = vec_idx_q;
  assign lane_en    = lane_en_q;
  assign vec_last   = vec_last_q;

endmodule
